// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address and
// loads the returned word into the IF/ID register, with stall, redirect and fault handling.
module fetch_stage #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned IMEM_BYTES = 64,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [63:0] redirect_pc_i,
    output logic [63:0] imem_adr_o,
    input  logic [31:0] imem_instr_i,
    output logic [63:0] if_id_pc_o,
    output logic [31:0] if_id_instr_o,
    output logic        if_id_valid_o,
    output logic        fault_o,
    output logic        halted_o,
    output logic [31:0] fetch_count_o
);

    // state   | meaning
    // ST_RUN  | fetching; honours redirect, stall and PC legality in that order
    // ST_HALT | fetch fault seen; everything frozen until reset
    typedef enum logic {ST_RUN, ST_HALT} state_t;

    localparam logic [63:0] LAST_PC = 64'(IMEM_BYTES) - 64'd4;

    state_t      state, state_nxt;
    logic [63:0] pc;
    logic        pc_legal, redir_legal;
    logic        do_flush, do_fetch, do_bad_pc, do_fault;

    assign imem_adr_o  = pc;
    assign pc_legal    = (pc[1:0] == 2'b00) && (pc <= LAST_PC);
    assign redir_legal = (redirect_pc_i[1:0] == 2'b00) && (redirect_pc_i <= LAST_PC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_RUN) begin
            if (redirect_i) begin
                if (!redir_legal) begin
                    state_nxt = ST_HALT;
                end
            end else if (!stall_i && !pc_legal) begin
                state_nxt = ST_HALT;
            end
        end
    end

    always_comb begin
        halted_o  = (state == ST_HALT);
        do_flush  = (state == ST_RUN) && redirect_i;
        do_fetch  = (state == ST_RUN) && !redirect_i && !stall_i && pc_legal;
        do_bad_pc = (state == ST_RUN) && !redirect_i && !stall_i && !pc_legal;
        do_fault  = do_bad_pc || (do_flush && !redir_legal);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc            <= RESET_PC;
            if_id_pc_o    <= 64'h0;
            if_id_instr_o <= NOP_INSTR;
            if_id_valid_o <= 1'b0;
            fault_o       <= 1'b0;
            fetch_count_o <= 32'h0;
        end else begin
            if (do_flush) begin
                // A redirect keeps if_id_pc_o; only the instruction slot is squashed.
                pc            <= redirect_pc_i;
                if_id_instr_o <= NOP_INSTR;
                if_id_valid_o <= 1'b0;
            end
            if (do_bad_pc) begin
                if_id_instr_o <= NOP_INSTR;
                if_id_valid_o <= 1'b0;
            end
            if (do_fetch) begin
                pc            <= pc + 64'd4;
                if_id_pc_o    <= pc;
                if_id_instr_o <= imem_instr_i;
                if_id_valid_o <= 1'b1;
                if (fetch_count_o != 32'hFFFF_FFFF) begin
                    fetch_count_o <= fetch_count_o + 32'd1;
                end
            end
            if (do_fault) begin
                fault_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 16-byte instruction memory: table of
// per-edge vectors plus hand sequences for async reset and misaligned redirect.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        redirect_i;
    logic [63:0] redirect_pc_i;
    logic [63:0] imem_adr_o;
    logic [31:0] imem_instr_i;
    logic [63:0] if_id_pc_o;
    logic [31:0] if_id_instr_o;
    logic        if_id_valid_o;
    logic        fault_o;
    logic        halted_o;
    logic [31:0] fetch_count_o;

    logic [31:0] mem [4];
    int n_vec = 0;
    int n_bad = 0;

    localparam logic [31:0] NOP = 32'h00000013;

    fetch_stage #(.RESET_PC(64'h0), .IMEM_BYTES(16), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .imem_adr_o(imem_adr_o), .imem_instr_i(imem_instr_i),
        .if_id_pc_o(if_id_pc_o), .if_id_instr_o(if_id_instr_o), .if_id_valid_o(if_id_valid_o),
        .fault_o(fault_o), .halted_o(halted_o), .fetch_count_o(fetch_count_o)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (imem_adr_o < 64'd16 && imem_adr_o[1:0] == 2'b00)
            imem_instr_i = mem[imem_adr_o[3:2]];
        else
            imem_instr_i = 32'hBAADF00D;
    end

    typedef struct {
        logic        stall;
        logic        redir;
        logic [63:0] rpc;
        logic [63:0] adr;
        logic [63:0] ipc;
        logic [31:0] instr;
        logic        valid;
        logic        fault;
        logic        halted;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [63:0] adr, input logic [63:0] ipc,
                         input logic [31:0] instr, input logic valid, input logic fault,
                         input logic halted, input logic [31:0] cnt);
        n_vec++;
        if (imem_adr_o !== adr || if_id_pc_o !== ipc || if_id_instr_o !== instr ||
            if_id_valid_o !== valid || fault_o !== fault || halted_o !== halted ||
            fetch_count_o !== cnt) begin
            n_bad++;
            $display("FAIL %s: got adr=%0h pc=%0h instr=%h v=%b f=%b h=%b cnt=%0d, want adr=%0h pc=%0h instr=%h v=%b f=%b h=%b cnt=%0d",
                     name, imem_adr_o, if_id_pc_o, if_id_instr_o, if_id_valid_o, fault_o,
                     halted_o, fetch_count_o, adr, ipc, instr, valid, fault, halted, cnt);
        end
    endtask

    task automatic edge_drive(input logic st, input logic rd, input logic [63:0] rpc);
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        mem[0] = 32'h00002103;
        mem[1] = 32'h002100B3;
        mem[2] = 32'h00102623;
        mem[3] = 32'h00C02183;

        //           stall redir rpc  adr  ipc  instr         v  f  h  cnt
        vecs[0]  = '{0, 0, 64'd0, 64'd4,  64'd0,  32'h00002103, 1, 0, 0, 1};
        vecs[1]  = '{0, 0, 64'd0, 64'd8,  64'd4,  32'h002100B3, 1, 0, 0, 2};
        vecs[2]  = '{0, 0, 64'd0, 64'd12, 64'd8,  32'h00102623, 1, 0, 0, 3};
        vecs[3]  = '{0, 0, 64'd0, 64'd16, 64'd12, 32'h00C02183, 1, 0, 0, 4};
        vecs[4]  = '{0, 1, 64'd4, 64'd4,  64'd12, NOP,          0, 0, 0, 4};
        vecs[5]  = '{0, 0, 64'd0, 64'd8,  64'd4,  32'h002100B3, 1, 0, 0, 5};
        vecs[6]  = '{1, 0, 64'd0, 64'd8,  64'd4,  32'h002100B3, 1, 0, 0, 5};
        vecs[7]  = '{1, 0, 64'd0, 64'd8,  64'd4,  32'h002100B3, 1, 0, 0, 5};
        vecs[8]  = '{0, 0, 64'd0, 64'd12, 64'd8,  32'h00102623, 1, 0, 0, 6};
        vecs[9]  = '{1, 1, 64'd4, 64'd4,  64'd8,  NOP,          0, 0, 0, 6};
        vecs[10] = '{0, 0, 64'd0, 64'd8,  64'd4,  32'h002100B3, 1, 0, 0, 7};
        vecs[11] = '{0, 0, 64'd0, 64'd12, 64'd8,  32'h00102623, 1, 0, 0, 8};
        vecs[12] = '{0, 0, 64'd0, 64'd16, 64'd12, 32'h00C02183, 1, 0, 0, 9};
        vecs[13] = '{0, 0, 64'd0, 64'd16, 64'd12, NOP,          0, 1, 1, 9};
        vecs[14] = '{0, 1, 64'd0, 64'd16, 64'd12, NOP,          0, 1, 1, 9};
        vecs[15] = '{1, 0, 64'd0, 64'd16, 64'd12, NOP,          0, 1, 1, 9};

        reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 64'h0;
        #2;
        check("reset_values", 64'd0, 64'd0, NOP, 0, 0, 0, 0);
        #5 reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            edge_drive(vecs[i].stall, vecs[i].redir, vecs[i].rpc);
            check($sformatf("vec%0d", i), vecs[i].adr, vecs[i].ipc, vecs[i].instr,
                  vecs[i].valid, vecs[i].fault, vecs[i].halted, vecs[i].cnt);
        end

        // Async reset while halted and stalling; must clear before any edge.
        #2 reset = 1'b1;
        #1 check("reset_from_halt", 64'd0, 64'd0, NOP, 0, 0, 0, 0);
        #2 reset = 1'b0;
        edge_drive(0, 0, 64'd0);
        check("first_after_reset", 64'd4, 64'd0, 32'h00002103, 1, 0, 0, 1);

        // Misaligned redirect faults on its own edge and never delivers pc 6.
        edge_drive(0, 1, 64'd6);
        check("misaligned_redirect", 64'd6, 64'd0, NOP, 0, 1, 1, 1);
        edge_drive(0, 0, 64'd0);
        check("misaligned_hold1", 64'd6, 64'd0, NOP, 0, 1, 1, 1);
        edge_drive(0, 1, 64'd4);
        check("misaligned_hold2", 64'd6, 64'd0, NOP, 0, 1, 1, 1);

        // Async reset mid-run while pc = 12.
        reset = 1'b1;
        #2 reset = 1'b0;
        edge_drive(0, 0, 64'd0);
        edge_drive(0, 0, 64'd0);
        edge_drive(0, 0, 64'd0);
        check("run_to_pc12", 64'd12, 64'd8, 32'h00102623, 1, 0, 0, 3);
        stall_i = 1'b1;
        #2 reset = 1'b1;
        #1 check("async_reset_midrun", 64'd0, 64'd0, NOP, 0, 0, 0, 0);
        #2 reset = 1'b0;
        edge_drive(0, 0, 64'd0);
        check("resume_after_reset", 64'd4, 64'd0, 32'h00002103, 1, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1);
    end

endmodule
